lu_arbiter: RTL and testbench

Round-robin scheduler that shares one N-bit logic unit (bitwise AND, OR, NOT and 2:1 mux, built from the team's N-bit gate primitives) between R requesters. Each requester presents an operation with a valid/ready handshake. The block grants at most one request per cycle, computes the result, and holds it in a single output register until the consumer accepts it. It sits between the instruction-side clients and the shared logic datapath.

---
 rtl/lu_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_lu_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lu_arbiter (plus the N-bit gate primitives it is built from)
// Purpose  : Round-robin scheduler sharing one N-bit logic unit (AND, OR, NOT,
//            2:1 mux) between R requesters. At most one request is granted
//            per cycle. Its result is held in a single output register until
//            the consumer takes it.
// Ports    : clk_i        - clock, rising edge
//            reset_i      - synchronous, active-high reset
//            req_valid_i  - [R]   per-requester operation pending
//            req_ready_o  - [R]   one-hot grant (combinational)
//            req_op_i     - [2R]  op of requester i at [2i+1:2i]
//            req_a_i      - [N*R] operand a of requester i at [N*i+N-1:N*i]
//            req_b_i      - [N*R] operand b, same packing
//            req_sel_i    - [R]   mux select per requester
//            resp_valid_o - result register holds a result
//            resp_ready_i - consumer accepts the result this cycle
//            resp_id_o    - [clog2(R)] owner of the held result
//            resp_data_o  - [N]   held result
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// N-bit gate primitives
// ----------------------------------------------------------------------------
module lu_and_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign y_o[gi] = a_i[gi] & b_i[gi];
  end
endmodule

module lu_or_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign y_o[gi] = a_i[gi] | b_i[gi];
  end
endmodule

module lu_not_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign y_o[gi] = ~a_i[gi];
  end
endmodule

module lu_mux2_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sel_i,
  output logic [N-1:0] y_o
);
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign y_o[gi] = sel_i ? b_i[gi] : a_i[gi];
  end
endmodule

// ----------------------------------------------------------------------------
// Top: arbiter + shared logic unit + result slot
// ----------------------------------------------------------------------------
module lu_arbiter #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [R-1:0]         req_valid_i,
  output logic [R-1:0]         req_ready_o,
  input  logic [2*R-1:0]       req_op_i,
  input  logic [N*R-1:0]       req_a_i,
  input  logic [N*R-1:0]       req_b_i,
  input  logic [R-1:0]         req_sel_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [$clog2(R)-1:0] resp_id_o,
  output logic [N-1:0]         resp_data_o
);

  localparam int W = $clog2(R);

  localparam logic [1:0] C_OP_AND = 2'b00;
  localparam logic [1:0] C_OP_OR  = 2'b01;
  localparam logic [1:0] C_OP_NOT = 2'b10;
  localparam logic [1:0] C_OP_MUX = 2'b11;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   ptr_q,   ptr_d;
  logic [W-1:0]   id_q,    id_d;
  logic [N-1:0]   data_q,  data_d;

  // Unpacked per-requester views of the packed request buses
  logic [1:0]     w_op_arr [R];
  logic [N-1:0]   w_a_arr  [R];
  logic [N-1:0]   w_b_arr  [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_unpack
    assign w_op_arr[gi] = req_op_i[2*gi +: 2];
    assign w_a_arr[gi]  = req_a_i[N*gi +: N];
    assign w_b_arr[gi]  = req_b_i[N*gi +: N];
  end

  // --------------------------------------------------------------------------
  // Round-robin scan: start at ptr_q and wrap; W-bit addition wraps mod R
  // because R is a power of two.
  // --------------------------------------------------------------------------
  logic         w_gnt_found;
  logic [W-1:0] w_gnt_idx;
  logic [W-1:0] w_scan_idx;

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < R; k++) begin
      w_scan_idx = ptr_q + W'(k);
      if (!w_gnt_found && req_valid_i[w_scan_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan_idx;
      end
    end
  end

  // The slot can take a new result when empty, or when the held result is
  // leaving this same cycle. Nothing is granted while reset is asserted.
  logic w_grant_allowed;
  logic w_req_xfer;

  assign w_grant_allowed = !reset_i && ((state_q == S_EMPTY) || resp_ready_i);
  assign w_req_xfer      = w_grant_allowed && w_gnt_found;

  always_comb begin
    req_ready_o = '0;
    if (w_req_xfer) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Shared logic unit, fed with the granted requester's operands
  // --------------------------------------------------------------------------
  logic [1:0]   w_op;
  logic [N-1:0] w_a, w_b;
  logic         w_sel;
  logic [N-1:0] w_and_y, w_or_y, w_not_y, w_mux_y;
  logic [N-1:0] w_result;

  assign w_op  = w_op_arr[w_gnt_idx];
  assign w_a   = w_a_arr[w_gnt_idx];
  assign w_b   = w_b_arr[w_gnt_idx];
  assign w_sel = req_sel_i[w_gnt_idx];

  lu_and_n  #(.N(N)) u_and  (.a_i(w_a), .b_i(w_b), .y_o(w_and_y));
  lu_or_n   #(.N(N)) u_or   (.a_i(w_a), .b_i(w_b), .y_o(w_or_y));
  lu_not_n  #(.N(N)) u_not  (.a_i(w_a), .y_o(w_not_y));
  lu_mux2_n #(.N(N)) u_mux  (.a_i(w_a), .b_i(w_b), .sel_i(w_sel), .y_o(w_mux_y));

  always_comb begin
    w_result = w_and_y;
    case (w_op)
      C_OP_AND: w_result = w_and_y;
      C_OP_OR:  w_result = w_or_y;
      C_OP_NOT: w_result = w_not_y;
      C_OP_MUX: w_result = w_mux_y;
      default:  w_result = w_and_y;
    endcase
  end

  // --------------------------------------------------------------------------
  // Slot FSM and result/pointer next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (w_req_xfer) state_d = S_FULL;
      // A simultaneous new grant keeps the slot full (back-to-back)
      S_FULL:  if (resp_ready_i && !w_req_xfer) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    id_d   = id_q;
    data_d = data_q;
    if (w_req_xfer) begin
      ptr_d  = w_gnt_idx + W'(1);
      id_d   = w_gnt_idx;
      data_d = w_result;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign resp_valid_o = (state_q == S_FULL);
  assign resp_id_o    = id_q;
  assign resp_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_arbiter
// Purpose  : Self-checking bench for lu_arbiter (N=8, R=4). Directed scenarios
//            plus a randomized run, all compared against a behavioural model
//            of the slot, round-robin pointer and logic operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [2*R-1:0] req_op;
  logic [N*R-1:0] req_a;
  logic [N*R-1:0] req_b;
  logic [R-1:0]   req_sel;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_id;
  logic [N-1:0]   resp_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_ptr;
  bit         m_full;
  logic [7:0] m_data;
  int         m_id;

  lu_arbiter #(.N(N), .R(R)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_sel_i    (req_sel),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_data_o  (resp_data)
  );

  always #5 clk = ~clk;

  // First valid index scanning from p upward, modulo R; -1 if none
  function automatic int f_grant(logic [R-1:0] v, int p, bit allowed);
    if (!allowed) return -1;
    for (int k = 0; k < R; k++) begin
      if (v[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  function automatic logic [7:0] f_op(logic [1:0] op, logic [7:0] a, logic [7:0] b, logic s);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~a;
      default: return s ? b : a;
    endcase
  endfunction

  function automatic logic [R-1:0] f_exp_ready();
    int g;
    if (reset) return '0;
    g = f_grant(req_valid, m_ptr, !m_full || resp_ready);
    if (g < 0) return '0;
    return R'(1) << g;
  endfunction

  // Update the model with the inputs that will be sampled at the next edge
  task automatic model_step();
    int g;
    if (reset) begin
      m_full = 0; m_data = '0; m_id = 0; m_ptr = 0;
    end else begin
      g = f_grant(req_valid, m_ptr, !m_full || resp_ready);
      if (g >= 0) begin
        m_data = f_op(req_op[2*g +: 2], req_a[8*g +: 8], req_b[8*g +: 8], req_sel[g]);
        m_id   = g;
        m_full = 1;
        m_ptr  = (g + 1) % R;
      end else if (m_full && resp_ready) begin
        m_full = 0;
      end
    end
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [7:0] a, logic [7:0] b, logic s);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_sel[i]       = s;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; resp_ready = 1'b1;
    advance();
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; resp_ready = 1'b1;
    req_a = $urandom; req_b = $urandom; req_op = $urandom; req_sel = $urandom;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000)
        begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      advance();
    end
    reset = 1'b0; req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_data !== 8'h00)
      begin errors++; $display("FAIL reset_state: got v=%b id=%0d d=%h want 0/0/00", resp_valid, resp_id, resp_data); end
  endtask

  task automatic test_single_op();
    do_reset();
    set_req(2, 2'b00, 8'hF0, 8'h3C, 1'b0);
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100)
      begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    advance();
    // ptr must now be 3: with everyone valid, requester 3 wins
    req_valid = 4'b1111;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 8'h30)
      begin errors++; $display("FAIL single_result: got v=%b id=%0d d=%h want 1/2/30", resp_valid, resp_id, resp_data); end
    checks++;
    if (req_ready !== 4'b1000)
      begin errors++; $display("FAIL single_ptr: got %b want 1000", req_ready); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_all_ops();
    logic [1:0] ops  [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic       sels [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] exps [4] = '{8'hAF, 8'h5A, 8'hA5, 8'h0F};
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, ops[t], 8'hA5, 8'h0F, sels[t]);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001)
        begin errors++; $display("FAIL ops_grant%0d: got %b want 0001", t, req_ready); end
      advance();
      req_valid = '0;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== exps[t])
        begin errors++; $display("FAIL ops_result%0d: got v=%b id=%0d d=%h want 1/0/%h", t, resp_valid, resp_id, resp_data, exps[t]); end
      advance();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < R; i++) set_req(i, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== (4'b0001 << (k % 4)))
        begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      if (k > 0) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((k - 1) % 4) || resp_data !== m_data)
          begin errors++; $display("FAIL rr_resp%0d: got v=%b id=%0d d=%h want 1/%0d/%h", k, resp_valid, resp_id, resp_data, (k - 1) % 4, m_data); end
      end
      advance();
    end
    req_valid = '0;
    advance();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(2, 2'b00, 8'hF0, 8'h3C, 1'b0);
    req_valid = 4'b0100; resp_ready = 1'b0;
    advance();
    set_req(1, 2'b01, 8'h12, 8'h40, 1'b0);
    req_valid = 4'b0010; resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 8'h30)
        begin errors++; $display("FAIL bp_hold%0d: got rdy=%b v=%b id=%0d d=%h want 0000/1/2/30", c, req_ready, resp_valid, resp_id, resp_data); end
      advance();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010)
      begin errors++; $display("FAIL bp_release: got %b want 0010", req_ready); end
    advance();
    req_valid = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'h52)
      begin errors++; $display("FAIL bp_result: got v=%b id=%0d d=%h want 1/1/52", resp_valid, resp_id, resp_data); end
    advance();
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_req(0, 2'b01, 8'h01, 8'h02, 1'b0);
    req_valid = 4'b0001; resp_ready = 1'b1;
    advance();
    set_req(3, 2'b10, 8'h0F, 8'h00, 1'b0);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000)
      begin errors++; $display("FAIL skip_first: got %b want 1000", req_ready); end
    advance();
    #1;
    checks++;
    if (req_ready !== 4'b0001 || resp_id !== 2'd3 || resp_data !== 8'hF0)
      begin errors++; $display("FAIL skip_second: got rdy=%b id=%0d d=%h want 0001/3/F0", req_ready, resp_id, resp_data); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_reset_mid();
    set_req(1, 2'b01, 8'h11, 8'h22, 1'b0);
    req_valid = 4'b0010; resp_ready = 1'b0;
    advance();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000)
      begin errors++; $display("FAIL rstmid_ready: got %b want 0000", req_ready); end
    advance();
    reset = 1'b0;
    set_req(3, 2'b00, 8'hFF, 8'h0F, 1'b0);
    req_valid = 4'b1010; resp_ready = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 2'd0)
      begin errors++; $display("FAIL rstmid_state: got v=%b id=%0d d=%h want 0/0/00", resp_valid, resp_id, resp_data); end
    checks++;
    if (req_ready !== 4'b0010)
      begin errors++; $display("FAIL rstmid_grant: got %b want 0010", req_ready); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_random();
    logic [R-1:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      req_op     = 8'($urandom);
      req_a      = $urandom;
      req_b      = $urandom;
      req_sel    = 4'($urandom);
      #1;
      exp_rdy = f_exp_ready();
      checks++;
      if (req_ready !== exp_rdy)
        begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_rdy); end
      checks++;
      if (resp_valid !== m_full)
        begin errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, resp_valid, m_full); end
      if (m_full) begin
        checks++;
        if (resp_id !== 2'(m_id) || resp_data !== m_data)
          begin errors++; $display("FAIL rand_resp c%0d: got id=%0d d=%h want %0d/%h", c, resp_id, resp_data, m_id, m_data); end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_sel = '0;
    m_ptr = 0; m_full = 0; m_data = '0; m_id = 0;
    @(negedge clk);
    #1;
    test_reset();
    test_single_op();
    test_all_ops();
    test_round_robin();
    test_backpressure();
    test_pointer_skip();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
